// File: rtl/calc_pkg.sv
// Shared calculator-keypad definitions: encoder state codes, operator codes
// and the row/column key map consumed by the keypad encoder.
package calc_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned KEY_W   = 4;

    localparam logic [STATE_W-1:0] ST_SCAN     = 2'd0;
    localparam logic [STATE_W-1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD     = 2'd2;
    localparam logic [STATE_W-1:0] ST_RELEASE  = 2'd3;

    localparam logic [KEY_W-1:0] OP_ADD    = 4'hA;
    localparam logic [KEY_W-1:0] OP_SUB    = 4'hB;
    localparam logic [KEY_W-1:0] OP_MUL    = 4'hC;
    localparam logic [KEY_W-1:0] OP_DIV    = 4'hD;
    localparam logic [KEY_W-1:0] OP_CLEAR  = 4'hE;
    localparam logic [KEY_W-1:0] OP_EQUALS = 4'hF;

    // Indexed by {row, col}; entry 0 (row 0, column 0) is the rightmost element.
    localparam logic [15:0][KEY_W-1:0] KEY_MAP = {
        OP_DIV,   OP_EQUALS, 4'h0, OP_CLEAR,
        OP_MUL,   4'h9,      4'h8, 4'h7,
        OP_SUB,   4'h6,      4'h5, 4'h4,
        OP_ADD,   4'h3,      4'h2, 4'h1
    };

    function automatic logic [KEY_W-1:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

    // Index of the lowest-numbered row pulled low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_bcd_encoder_kp_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
module kp_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] s1_q;
    logic [3:0] s2_q;

    // Idle keypad reads all-high, so reset to that.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 4'hF;
            s2_q <= 4'hF;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/keypad_bcd_encoder.sv
// 4x4 keypad scanner: column scan, press/release debounce, one valid/ready
// transfer of the key code per press.
module keypad_bcd_encoder
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       busy
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 20;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    logic [3:0]         rs;
    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [1:0]         row_q, row_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   code_q, code_d;
    logic               valid_q, valid_d;
    logic [3:0]         col_out_q, col_out_d;
    logic               busy_q, busy_d;
    logic [DIV_W-1:0]   div_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               handshake;

    kp_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (row_in),
        .q       (rs)
    );

    assign div_inc   = (div_q == '1) ? div_q : div_q + DIV_W'(1);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign handshake = valid_q & key_ready;

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;

        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (rs != 4'hF) begin
                        row_d   = lowest_low_row(rs);
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (!rs[row_q]) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_DONE) begin
                        code_d  = key_lookup(row_q, col_q);
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_HOLD: begin
                // Key stays pending until consumed, even if released meanwhile.
                if (handshake) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rs == 4'hF) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_DONE) begin
                        col_d   = 2'd0;
                        div_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        col_out_d = ~(4'b0001 << col_d);
        busy_d    = (state_d != ST_SCAN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SCAN;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            div_q     <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            col_out_q <= 4'b1110;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            col_out_q <= col_out_d;
            busy_q    <= busy_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: physical keypad model, behavioural reference
// compared every cycle, directed scenarios and randomized presses.
module tb_keypad_bcd_encoder;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic key_ready = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic key_valid;
    logic busy;
    logic [3:0][3:0] pressed = '0;   // [row][col]

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    int valid_cycles = 0;
    logic [3:0] hs_codes[$];

    keypad_bcd_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // A row reads low when a pressed key connects it to the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(pressed[r] & ~col_out);
        end
    end

    typedef enum {M_SCAN, M_DEB, M_HOLD, M_REL} mphase_t;
    mphase_t    m_phase = M_SCAN;
    int         m_col = 0;
    int         m_row = 0;
    int         m_tick = 0;
    int         m_run = 0;
    logic [3:0] m_code = 4'h0;
    logic       m_valid = 1'b0;
    logic [3:0] m_s1 = 4'hF;
    logic [3:0] m_rs = 4'hF;
    int km[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    // Reference model, advanced once per clock from pre-edge values.
    initial forever begin : model
        logic [3:0] rows_now;
        logic [3:0] rs_old;
        bit hs;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_phase = M_SCAN; m_col = 0; m_row = 0; m_tick = 0; m_run = 0;
            m_code = 4'h0; m_valid = 1'b0; m_s1 = 4'hF; m_rs = 4'hF;
        end else begin
            for (int r = 0; r < 4; r++) rows_now[r] = ~pressed[r][m_col];
            rs_old = m_rs;
            hs = m_valid && key_ready;
            case (m_phase)
                M_SCAN: begin
                    m_tick++;
                    if (m_tick == SCAN_DIV) begin
                        m_tick = 0;
                        if (rs_old != 4'hF) begin
                            for (int r = 0; r < 4; r++) begin
                                if (!rs_old[r]) begin
                                    m_row = r;
                                    break;
                                end
                            end
                            m_run = 0;
                            m_phase = M_DEB;
                        end else begin
                            m_col = (m_col + 1) % 4;
                        end
                    end
                end
                M_DEB: begin
                    if (!rs_old[m_row]) begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_code = 4'(km[m_row][m_col]);
                            m_valid = 1'b1;
                            m_phase = M_HOLD;
                        end
                    end else begin
                        m_col = (m_col + 1) % 4;
                        m_tick = 0;
                        m_phase = M_SCAN;
                    end
                end
                M_HOLD: begin
                    if (hs) begin
                        m_valid = 1'b0;
                        m_run = 0;
                        m_phase = M_REL;
                    end
                end
                default: begin
                    if (rs_old == 4'hF) begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_col = 0;
                            m_tick = 0;
                            m_phase = M_SCAN;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            endcase
            m_rs = m_s1;
            m_s1 = rows_now;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin : compare
        logic [3:0] exp_col;
        logic exp_busy;
        @(negedge clk);
        if (reset_n) begin
            exp_col = 4'hF;
            exp_col[m_col] = 1'b0;
            exp_busy = (m_phase != M_SCAN);
            total++;
            if (col_out !== exp_col || key_valid !== m_valid || key_code !== m_code || busy !== exp_busy) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t col_out=%b/%b valid=%b/%b code=%h/%h busy=%b/%b (got/want)",
                         $time, col_out, exp_col, key_valid, m_valid, key_code, m_code, busy, exp_busy);
            end
        end
    end

    // Transfer monitor.
    initial forever begin
        @(posedge clk);
        if (reset_n && key_valid) valid_cycles++;
        if (reset_n && key_valid && key_ready) begin
            hs_count++;
            hs_codes.push_back(key_code);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        pressed = '0;
        key_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        cycles(2);
        check("rst_col", int'(col_out), 14);
        check("rst_valid", int'(key_valid), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
    endtask

    task automatic wait_col(input logic [3:0] want, input string name);
        int n = 0;
        while (col_out !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(col_out), int'(want));
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(key_valid), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin : stim
        int n;
        int base;
        int vbase;
        int col_bad;

        // Key 6 held 20 cycles with ready high.
        do_reset();
        key_ready = 1'b1;
        wait_col(4'b1011, "t1_wait_col2");
        base = hs_count;
        pressed[1][2] = 1'b1;
        wait_valid("t1_valid", n);
        check("t1_latency", n, 12);
        check("t1_code", int'(key_code), 6);
        cycles(20 - n);
        pressed = '0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_release_busy", n, 10);
        check("t1_hs", hs_count - base, 1);
        check("t1_hs_code", int'(hs_codes[$]), 6);

        // Key 0 held with ready low; transfer only when ready rises.
        do_reset();
        key_ready = 1'b0;
        wait_col(4'b1101, "t2_wait_col1");
        base = hs_count;
        pressed[3][1] = 1'b1;
        cycles(50);
        check("t2_valid_held", int'(key_valid), 1);
        check("t2_code", int'(key_code), 0);
        pressed = '0;
        cycles(30);
        check("t2_valid_after_release", int'(key_valid), 1);
        check("t2_no_hs_yet", hs_count - base, 0);
        key_ready = 1'b1;
        cycles(1);
        check("t2_valid_drop", int'(key_valid), 0);
        check("t2_hs", hs_count - base, 1);
        check("t2_hs_code", int'(hs_codes[$]), 0);
        wait_idle("t2_idle");

        // Five-cycle bounce on column 3 must be rejected.
        do_reset();
        key_ready = 1'b1;
        wait_col(4'b0111, "t3_wait_col3");
        base = hs_count;
        vbase = valid_cycles;
        pressed[0][3] = 1'b1;
        cycles(5);
        pressed = '0;
        cycles(3);
        check("t3_col_resume", int'(col_out), 14);
        check("t3_busy", int'(busy), 0);
        cycles(20);
        check("t3_no_valid", valid_cycles - vbase, 0);
        check("t3_no_hs", hs_count - base, 0);

        // Two keys on column 0: lowest row wins, no second pulse until full release.
        do_reset();
        key_ready = 1'b1;
        base = hs_count;
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        wait_valid("t4_valid", n);
        check("t4_code", int'(key_code), 1);
        cycles(20);
        pressed[0][0] = 1'b0;
        cycles(30);
        check("t4_single", hs_count - base, 1);
        check("t4_busy_held", int'(busy), 1);
        pressed = '0;
        wait_idle("t4_idle");
        pressed[2][0] = 1'b1;
        wait_valid("t4_valid2", n);
        check("t4_code2", int'(key_code), 7);
        cycles(3);
        check("t4_hs2", hs_count - base, 2);
        pressed = '0;
        wait_idle("t4_idle2");

        // Asynchronous reset during HOLD.
        do_reset();
        key_ready = 1'b0;
        pressed[0][1] = 1'b1;
        wait_valid("t5_valid", n);
        check("t5_code", int'(key_code), 2);
        cycles(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_valid", int'(key_valid), 0);
        check("t5_async_col", int'(col_out), 14);
        check("t5_async_busy", int'(busy), 0);
        check("t5_async_code", int'(key_code), 0);
        pressed = '0;
        @(negedge clk);
        reset_n = 1'b1;
        vbase = valid_cycles;
        cycles(2);
        check("t5_post_reset_valid", valid_cycles - vbase, 0);

        // Key 9 held 200 cycles: one transfer, column 2 held until release done.
        do_reset();
        key_ready = 1'b1;
        wait_col(4'b1011, "t6_wait_col2");
        base = hs_count;
        col_bad = 0;
        pressed[2][2] = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (col_out !== 4'b1011) col_bad++;
        end
        pressed = '0;
        n = 0;
        while (busy && n < 100) begin
            if (col_out !== 4'b1011) col_bad++;
            @(negedge clk);
            n++;
        end
        check("t6_col_held", col_bad, 0);
        check("t6_hs", hs_count - base, 1);
        check("t6_hs_code", int'(hs_codes[$]), 9);
        wait_idle("t6_idle");

        // Randomized presses, multi-key chords and bounces with random ready.
        for (int it = 0; it < 40; it++) begin
            int nk;
            nk = int'($urandom_range(1, 2));
            for (int k = 0; k < nk; k++) begin
                pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            end
            repeat ($urandom_range(1, 60)) begin
                @(negedge clk);
                key_ready = 1'($urandom_range(0, 1));
            end
            pressed = '0;
            repeat ($urandom_range(0, 40)) begin
                @(negedge clk);
                key_ready = 1'($urandom_range(0, 1));
            end
        end
        key_ready = 1'b1;
        wait_idle("rand_flush_idle");
        check("rand_final_valid", int'(key_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_bcd_encoder.md
KEYPAD_BCD_ENCODER -- requirements
Module: keypad_bcd_encoder

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column is driven before its rows are sampled (legal range 4..65535).
REQ-002 Parameter DEBOUNCE_CNT, default 500000, consecutive stable cycles needed to accept a press or a release (legal range 2..2^20-1).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 row_in  input  4  keypad rows; active-low; pulled up externally; asynchronous to clk.
REQ-006 col_out  output  4  keypad column drive; active-low, one-hot-low while scanning.
REQ-007 key_code  output  4  BCD digit 0-9, or operator code A-F, of the accepted key.
REQ-008 key_valid  output  1  key_code holds an accepted key that has not yet been consumed.
REQ-009 key_ready  input  1  consumer accepts key_code in any cycle where key_valid and key_ready are both high.
REQ-010 busy  output  1  high in every state except SCAN.

Function
REQ-011 row_in shall pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-012 States: SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-013 SCAN: drive column c low (c = 0,1,2,3 cyclic, wrapping 3->0); sample rs on the SCAN_DIV-th cycle of each column period.
REQ-014 SCAN sample with rs != 4'hF: capture c and the lowest-index low row r, clear the counter, go to DEBOUNCE with column c held; otherwise advance to column c+1.
REQ-015 DEBOUNCE: counter increments while rs[r] stays low; on reaching DEBOUNCE_CNT, load key_code from the map, set key_valid, and go to HOLD.
REQ-016 DEBOUNCE: if rs[r] goes high before the count completes, return to SCAN at column c+1 with no output.
REQ-017 Key map (row r / columns 0..3): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-018 HOLD: key_code and key_valid are held stable until handshake; on handshake, key_valid falls the next cycle and the state goes to RELEASE.
REQ-019 A release during HOLD shall not cancel key_valid; the key remains pending until consumed.
REQ-020 RELEASE: column c held; counter counts consecutive cycles with rs == 4'hF, clears on any low row; on reaching DEBOUNCE_CNT, go to SCAN column 0.
REQ-021 Exactly one key_valid pulse per press, however long the key is held (no auto-repeat).
REQ-022 Simultaneous presses: only the key found first in scan order (column, then lowest row) is reported; other keys are ignored until RELEASE completes.
REQ-023 Accept-to-key_valid latency = DEBOUNCE_CNT cycles after the SCAN sample, ±1 cycle.
REQ-024 Counters shall saturate, never wrap.

Reset
REQ-025 Asserting reset_n low at any time, including mid-debounce or mid-HOLD, shall immediately force state SCAN, column 0, col_out=4'b1110, key_code=0, key_valid=0, busy=0, counters=0, synchronizer=4'hF.
REQ-026 No key_valid shall be asserted within 2 cycles after reset release.

Structure
REQ-027 The state encoding, the 16-entry key-map constant, and the operator codes (A=add, B=sub, C=mul, D=div, E=clear, F=equals) shall live in a shared calc_pkg.
REQ-028 One sub-module, kp_sync (2-flop 4-bit synchronizer), is natural; everything else is flat.
REQ-029 key_code shall be directly consumable by the existing BCD-to-7-segment decoder.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-030 Hold row 1 low while column 2 is driven for 20 cycles, key_ready=1 -> one key_valid pulse with key_code=6, then busy until 8 cycles after release.
REQ-031 Press row 3 / column 1 with key_ready=0 for 50 cycles, then release -> key_valid=1, key_code=0 held stable throughout; one transfer when key_ready rises.
REQ-032 Row 0 low for 5 cycles during column 3 (bounce) -> no key_valid; scan resumes at column 0.
REQ-033 Rows 0 and 2 low together on column 0 -> key_code=1 only; a second pulse only after full release.
REQ-034 Assert reset_n low during HOLD with key_valid=1 -> key_valid=0 and col_out=4'b1110 in the same cycle, asynchronously.
REQ-035 Hold key 9 for 200 cycles -> exactly one handshake; col_out stays 4'b1011 until release debounce completes.
